// File: rtl/cpu_trace_checker_pkg.sv
// Shared types for the cpu trace checker: checker FSM states and the layout of
// one expected-trace entry.
package cpu_trace_checker_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RUN,
    DONE
  } chk_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] result;
    logic            zero;
  } trace_entry_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/cpu_trace_checker_trace_mem.sv
// Expected-trace storage: synchronous write port, combinational read port so the
// checker can compare the cpu outputs against the entry in the same cycle.
module cpu_trace_checker_trace_mem #(
  parameter  int WIDTH = 129,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents deliberately survive reset so a run can be repeated after an abort.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_trace_checker.sv
// Sequences cpu reset, then compares each running cycle of pc/alu_result/alu_zero
// against the preloaded expected trace and reports pass, error count and first error.
module cpu_trace_checker #(
  parameter  int XLEN       = 64,
  parameter  int DEPTH      = 16,
  parameter  int RST_CYCLES = 1,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            exp_we,
  input  logic [AW-1:0]   exp_addr,
  input  logic [XLEN-1:0] exp_pc,
  input  logic [XLEN-1:0] exp_result,
  input  logic            exp_zero,
  input  logic [AW:0]     exp_count,
  output logic            cpu_reset,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [7:0]      err_count,
  output logic [AW-1:0]   first_err
);

  import cpu_trace_checker_pkg::*;

  localparam int CW = AW + 1;
  localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int W  = 2 * XLEN + 1;

  chk_state_t    state, state_next;
  logic [HW-1:0] hold_cnt, hold_next;
  logic [CW-1:0] idx, idx_next;
  logic [CW-1:0] n_q, n_next, n_clamped;
  logic [7:0]    err_next;
  logic [AW-1:0] first_next;
  logic          cpu_reset_next, done_next, pass_next;
  logic          mem_we, mismatch;
  logic [W-1:0]  mem_rdata;

  assign n_clamped = (exp_count > CW'(DEPTH)) ? CW'(DEPTH) : exp_count;
  assign mem_we    = exp_we && (state == IDLE);
  assign mismatch  = (mem_rdata != {pc, alu_result, alu_zero});
  assign busy      = (state == HOLD) || (state == RUN);

  cpu_trace_checker_trace_mem #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_trace_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (exp_addr),
    .wdata ({exp_pc, exp_result, exp_zero}),
    .raddr (idx[AW-1:0]),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    idx_next   = idx;
    n_next     = n_q;
    err_next   = err_count;
    first_next = first_err;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          n_next     = n_clamped;
          idx_next   = '0;
          hold_next  = '0;
          err_next   = '0;
          first_next = '0;
          state_next = (n_clamped == '0) ? DONE : HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt == HW'(RST_CYCLES - 1)) begin
          state_next = RUN;
        end else begin
          hold_next = hold_cnt + HW'(1);
        end
      end
      RUN: begin
        idx_next = idx + CW'(1);
        if (mismatch) begin
          err_next = sat_inc8(err_count);
          if (err_count == 8'd0) begin
            first_next = idx[AW-1:0];
          end
        end
        // n never exceeds DEPTH, so idx reaches the last step before it could wrap.
        if (idx == n_q - CW'(1)) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
    cpu_reset_next = (state_next != RUN);
    done_next      = (state_next == DONE);
    pass_next      = (state_next == DONE) && (err_next == 8'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      idx       <= '0;
      n_q       <= '0;
      err_count <= '0;
      first_err <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state     <= state_next;
      hold_cnt  <= hold_next;
      idx       <= idx_next;
      n_q       <= n_next;
      err_count <= err_next;
      first_err <= first_next;
      cpu_reset <= cpu_reset_next;
      done      <= done_next;
      pass      <= pass_next;
    end
  end

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Bench for cpu_trace_checker: a stand-in cpu plays a fixed trace while a
// behavioural model predicts the outcome of directed and randomized runs.
module tb_cpu_trace_checker;

  import cpu_trace_checker_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        exp_we = 1'b0;
  logic [3:0]  exp_addr = '0;
  logic [63:0] exp_pc = '0;
  logic [63:0] exp_result = '0;
  logic        exp_zero = 1'b0;
  logic [4:0]  exp_count = '0;
  logic        cpu_reset;
  logic [63:0] pc;
  logic [63:0] alu_result;
  logic        alu_zero;
  logic        busy, done, pass;
  logic [7:0]  err_count;
  logic [3:0]  first_err;

  int checks = 0;
  int failures = 0;

  logic [63:0]  cpu_res [32];
  trace_entry_t mem_m [16];
  logic [5:0]   cyc = '0;

  cpu_trace_checker dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .exp_we     (exp_we),
    .exp_addr   (exp_addr),
    .exp_pc     (exp_pc),
    .exp_result (exp_result),
    .exp_zero   (exp_zero),
    .exp_count  (exp_count),
    .cpu_reset  (cpu_reset),
    .pc         (pc),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .first_err  (first_err)
  );

  always #5 clk = ~clk;

  // Stand-in cpu: held at step 0 while in reset, advances one step per cycle otherwise.
  always @(posedge clk) begin
    if (cpu_reset) cyc <= '0;
    else           cyc <= cyc + 6'd1;
  end

  function automatic trace_entry_t cpu_entry(input int k);
    trace_entry_t e;
    e.pc     = 64'(k) * 64'd4;
    e.result = cpu_res[k % 32];
    e.zero   = (cpu_res[k % 32] == 64'd0);
    return e;
  endfunction

  assign pc         = {56'd0, cyc, 2'b00};
  assign alu_result = cpu_res[cyc[4:0]];
  assign alu_zero   = (alu_result == 64'd0);

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic go_idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_entry(input int addr, input trace_entry_t e, input bit update_model);
    exp_we     = 1'b1;
    exp_addr   = 4'(addr);
    exp_pc     = e.pc;
    exp_result = e.result;
    exp_zero   = e.zero;
    @(negedge clk);
    exp_we = 1'b0;
    if (update_model) mem_m[addr] = e;
  endtask

  // Starts a run and follows it to DONE; optionally aborts with reset or pokes
  // start/exp_we once the given number of running cycles has been observed.
  task automatic applyStimulus(input int n_req, input int abort_at, input int inject_at, input string tag);
    int waited, low, n_eff, errs, first;
    trace_entry_t bogus;
    n_eff = (n_req > 16) ? 16 : n_req;
    errs  = 0;
    first = 0;
    for (int k = 0; k < n_eff; k++) begin
      if (mem_m[k] !== cpu_entry(k)) begin
        if (errs == 0) first = k;
        errs++;
      end
    end
    exp_count = 5'(n_req);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 1;
    low = 0;
    if (n_eff > 0) checkOutput({tag, "_busy"}, busy, 1);
    while (!done && waited < 200) begin
      start  = 1'b0;
      exp_we = 1'b0;
      if (!cpu_reset) begin
        if (low == abort_at) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          checkOutput({tag, "_cpu_reset"}, cpu_reset, 1);
          checkOutput({tag, "_err"}, err_count, 0);
          checkOutput({tag, "_first"}, first_err, 0);
          checkOutput({tag, "_busy_idle"}, busy, 0);
          checkOutput({tag, "_done"}, done, 0);
          return;
        end
        if (low == inject_at) begin
          bogus      = cpu_entry(0);
          start      = 1'b1;
          exp_we     = 1'b1;
          exp_addr   = 4'd0;
          exp_pc     = ~bogus.pc;
          exp_result = ~bogus.result;
          exp_zero   = ~bogus.zero;
        end
        low++;
      end
      @(negedge clk);
      waited++;
    end
    start  = 1'b0;
    exp_we = 1'b0;
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_pass"}, pass, (errs == 0) ? 1 : 0);
    checkOutput({tag, "_err"}, err_count, 64'(errs));
    checkOutput({tag, "_first"}, first_err, 64'(first));
    checkOutput({tag, "_cpu_reset"}, cpu_reset, 1);
    checkOutput({tag, "_low_cycles"}, 64'(low), 64'(n_eff));
    checkOutput({tag, "_busy_done"}, busy, 0);
    if (n_eff == 0) checkOutput({tag, "_latency"}, 64'(waited), 1);
  endtask

  initial begin
    trace_entry_t e;
    for (int i = 0; i < 32; i++) cpu_res[i] = {$urandom, $urandom};
    cpu_res[1] = 64'd0;
    cpu_res[2] = 64'd5;

    repeat (2) @(negedge clk);
    checkOutput("rst_cpu_reset", cpu_reset, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_err", err_count, 0);
    checkOutput("rst_first", first_err, 0);
    reset = 1'b0;

    for (int k = 0; k < 16; k++) write_entry(k, cpu_entry(k), 1);
    $display("[TB] scenario 1: matching 4-step trace");
    applyStimulus(4, -1, -1, "s1");

    $display("[TB] scenario 2: entry 2 result corrupted");
    go_idle();
    e = cpu_entry(2);
    e.result = 64'd6;
    write_entry(2, e, 1);
    applyStimulus(4, -1, -1, "s2");

    $display("[TB] scenario 3: entries 1 and 3 wrong");
    go_idle();
    write_entry(2, cpu_entry(2), 1);
    e = cpu_entry(1);
    e.pc = e.pc + 64'd4;
    write_entry(1, e, 1);
    e = cpu_entry(3);
    e.zero = ~e.zero;
    write_entry(3, e, 1);
    applyStimulus(4, -1, -1, "s3");

    $display("[TB] scenario 4: zero-length run");
    applyStimulus(0, -1, -1, "s4");

    $display("[TB] scenario 5: reset during run, then rerun");
    go_idle();
    write_entry(1, cpu_entry(1), 1);
    write_entry(3, cpu_entry(3), 1);
    applyStimulus(4, 2, -1, "s5_abort");
    applyStimulus(4, -1, -1, "s5_rerun");

    $display("[TB] exp_we while DONE is ignored");
    e = cpu_entry(0);
    e.result = ~e.result;
    write_entry(0, e, 0);
    applyStimulus(4, -1, -1, "done_we");

    $display("[TB] scenario 6: start/exp_we during run, clamped length");
    applyStimulus(20, -1, 3, "s6");
    applyStimulus(16, -1, -1, "s6_recheck");

    $display("[TB] start together with exp_we in IDLE");
    go_idle();
    e = cpu_entry(0);
    e.pc = 64'hDEAD;
    mem_m[0] = e;
    exp_we     = 1'b1;
    exp_addr   = 4'd0;
    exp_pc     = e.pc;
    exp_result = e.result;
    exp_zero   = e.zero;
    applyStimulus(3, -1, -1, "start_we");

    $display("[TB] randomized runs");
    for (int it = 0; it < 6; it++) begin
      go_idle();
      for (int k = 0; k < 16; k++) begin
        e = cpu_entry(k);
        if ($urandom_range(3) == 0) begin
          case ($urandom_range(2))
            0:       e.pc = e.pc ^ 64'(1 << $urandom_range(63));
            1:       e.result = e.result + 64'd1;
            default: e.zero = ~e.zero;
          endcase
        end
        write_entry(k, e, 1);
      end
      applyStimulus(int'($urandom_range(20)), -1, -1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
